store_buffer: RTL and testbench
===============================

# store_buffer

Queues formatted stores from the MEM stage and drains them to the data memory port one at a time over a req/ack handshake. It sits directly downstream of the store-data formatter. It consumes the byte-replicated write data and the lane-0-based byte-enable, and rotates the enable to the real byte lanes using the address. It also reports whether a load address hits a pending store, so the pipeline can stall the load until the store drains.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- st_valid  in  1  store presented this cycle
- st_ready  out  1  buffer can accept; equals !full
- st_addr  in  32  byte address of store
- st_data  in  32  write data, already byte/half-replicated
- st_we  in  4  lane-0-based enable: 0001 = sb, 0011 = sh, 1111 = sw, 0000 = not a store
- ld_valid  in  1  load address valid this cycle
- ld_addr  in  32  load byte address
- ld_hit  out  1  combinational; pending store overlaps load word
- mem_req  out  1  head entry presented to memory (registered)
- mem_addr  out  32  {head word address, 2'b00}
- mem_wdata  out  32  head data
- mem_wstrb  out  4  head byte strobe
- mem_ack  in  1  memory accepted head this cycle
- empty  out  1  no valid entries
- count  out  log2(DEPTH)+1  number of valid entries

## Operation
- Entry fields: word address st_addr[31:2], data st_data, strobe = (st_we << st_addr[1:0]) truncated to 4 bits.
- Enqueue occurs when st_valid && st_ready && st_we != 0. Entry is written at the tail and the tail pointer advances.
- st_valid && st_ready && st_we == 0 is accepted and dropped; no state change.
- Circular FIFO: head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH; count tracks occupancy; full when count == DEPTH.
- Drain: mem_req = !empty (registered view of state). mem_addr, mem_wdata and mem_wstrb come from the head entry and stay stable while mem_req && !mem_ack.
- Dequeue occurs on mem_ack && mem_req. Head advances. mem_ack while mem_req == 0 is ignored.
- ld_hit = ld_valid && any valid entry has word address == ld_addr[31:2]. A store being enqueued in the same cycle is not checked. ld_hit is 0 when ld_valid == 0.
- Misaligned sh/sw are not checked here. The strobe is simply truncated, and exception handling stays upstream.

## Timing
- Reset values: mem_req 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, empty 1, count 0, st_ready 1, ld_hit 0. Pointers are 0 and all entries are invalid.
- Enqueue into an empty buffer at edge N: mem_req = 1 with that entry's fields from cycle N+1. Minimum store-to-request latency is 1 cycle.
- Ack at edge N with more entries queued: next head is presented in cycle N+1 with mem_req held high, giving back-to-back 1 entry/cycle.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- Full: st_ready = 0 even if mem_ack is high the same cycle (no same-cycle bypass). st_ready returns to 1 the cycle after the ack.
- Reset mid-drain: all entries are discarded and mem_req falls in the cycle after the rst edge. The memory side must tolerate the abandoned request.
- ld_hit is purely combinational from ld_addr and current entry state. It clears the cycle after the matching entry is dequeued.

## Configuration
- STORE_MERGE_EN defined: an accepted store whose word address equals the tail-most valid entry merges into that entry instead of allocating, provided that entry is not the head with mem_req high.
  - Merged strobe = old | new.
  - Merged data takes new lanes where the new strobe is set and keeps old lanes elsewhere.
  - count is unchanged.
  - st_ready is still !full, so there is no merge into a full buffer.
- STORE_MERGE_EN undefined: every non-zero store allocates a new entry.

## Test plan
- sb with st_addr = 0x1003, st_data = 0xABABABAB, st_we = 0001 into an empty buffer -> next cycle mem_req = 1, mem_addr = 0x1000, mem_wstrb = 1000, mem_wdata = 0xABABABAB. Hold mem_ack = 0 for 3 cycles -> all outputs stable. Ack -> empty = 1 the next cycle.
- Enqueue 4 stores with mem_ack = 0 -> count = 4, st_ready = 0. A 5th st_valid is not accepted. Ack once -> st_ready = 1 the next cycle, and the 5th store enters with count = 4.
- Full buffer, st_valid and mem_ack high in the same cycle -> only the dequeue happens and count goes to 3. Then continuous ack drains one entry per cycle with the wrapped pointer order preserved (addresses in FIFO order).
- Pending sw to 0x2000, ld_addr = 0x2002, ld_valid = 1 -> ld_hit = 1. ld_addr = 0x2004 -> 0. After that entry is acked -> ld_hit = 0.
- rst asserted while mem_req = 1 with 3 entries -> next cycle mem_req 0, count 0, empty 1, st_ready 1.
- STORE_MERGE_EN: queue sw to 0x3000 (head, requesting), then sh to 0x3010 with data 0x12341234, then sb to 0x3011 with data 0x56565656 -> count = 2. The second entry has strobe 0011 and data low half 0x5634. Without the macro, count = 3.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Circular FIFO of formatted stores between the MEM stage and the data memory
// port. Each accepted store records its word address, its byte-replicated
// data, and a strobe. The strobe is the lane-0-based enable rotated onto the
// real byte lanes by the low address bits. The head entry is presented to
// memory over a req/ack handshake, one entry at a time. A load-address probe
// reports whether any pending store covers the same word, so the pipeline can
// stall that load until the store drains.
//
// Optional feature macro: STORE_MERGE_EN
//   When defined, a store to the same word as the tail-most valid entry is
//   merged into that entry instead of allocating a new one. The merge is not
//   done when that entry is the head currently being requested.
//   When undefined, every non-zero store allocates a new entry.
//
// Parameters
//   DEPTH     number of entries (power of two, >= 2)
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   st_valid  store presented this cycle
//   st_ready  buffer can accept a store (= !full)
//   st_addr   store byte address
//   st_data   store data, already byte/half replicated
//   st_we     lane-0-based byte enable (0001 sb, 0011 sh, 1111 sw, 0000 none)
//   ld_valid  load address valid this cycle
//   ld_addr   load byte address
//   ld_hit    a pending store covers the load's word (combinational)
//   mem_req   head entry presented to memory
//   mem_addr  head word address, byte-aligned
//   mem_wdata head data
//   mem_wstrb head byte strobe
//   mem_ack   memory accepted the head entry this cycle
//   empty     no valid entries
//   count     number of valid entries
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [3:0]                 st_we,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_ack,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Queue state
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [AW:0]      count_q;
  logic [DEPTH-1:0] valid_q;

  // Entry storage
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];

  logic [3:0]       new_strb;
  logic             full;
  logic             accept;
  logic             merge;
  logic             alloc;
  logic             deq;
  logic             unused_ok;

  // The load only probes at word granularity.
  assign unused_ok = &{1'b0, ld_addr[1:0]};

  // Rotate the lane-0-based enable onto the addressed lanes. Bits shifted past
  // lane 3 are dropped, because misalignment is trapped upstream.
  always_comb begin
    new_strb = st_we;
    case (st_addr[1:0])
      2'd0: new_strb = st_we;
      2'd1: new_strb = {st_we[2:0], 1'b0};
      2'd2: new_strb = {st_we[1:0], 2'b00};
      2'd3: new_strb = {st_we[0], 3'b000};
      default: new_strb = st_we;
    endcase
  end

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = !full;
  assign mem_req  = !empty;

  // Stores with an all-zero enable are accepted but dropped.
  assign accept   = st_valid && st_ready && (st_we != 4'b0000);
  assign deq      = mem_req && mem_ack;

`ifdef STORE_MERGE_EN
  logic [AW-1:0] last_idx;
  assign last_idx = tail_q - 1'b1;
  // Merge only into the youngest entry, and never into the head while it is
  // being requested, because memory may be latching its fields.
  assign merge = accept && !empty && valid_q[last_idx] &&
                 (addr_q[last_idx] == st_addr[31:2]) &&
                 !((last_idx == head_q) && mem_req);
`else
  assign merge = 1'b0;
`endif

  assign alloc = accept && !merge;

  // Pointers, occupancy and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every update in this block working
      // on the pre-edge state, so a simultaneous enqueue and dequeue is
      // order-independent.
      // head and tail only coincide when the buffer is empty or full. Neither
      // case allows both an alloc and a deq, so the two valid_q writes never
      // hit the same bit.
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(alloc) - (AW+1)'(deq);
    end
  end

  // NOTE: the entry payload is deliberately left out of reset. Only valid_q and
  // the pointers qualify it, so resetting wide storage would just cost area.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= st_addr[31:2];
      data_q[tail_q] <= st_data;
      strb_q[tail_q] <= new_strb;
    end
`ifdef STORE_MERGE_EN
    else if (merge) begin
      strb_q[last_idx] <= strb_q[last_idx] | new_strb;
      for (int b = 0; b < 4; b++) begin
        if (new_strb[b]) data_q[last_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
`endif
  end

  // The head fields are gated by mem_req. This keeps the port at zero while
  // the buffer is empty, including straight after reset.
  assign mem_addr  = mem_req ? {addr_q[head_q], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? data_q[head_q]          : 32'h0;
  assign mem_wstrb = mem_req ? strb_q[head_q]          : 4'h0;

  // A store being enqueued this cycle is not yet in valid_q, so it is not
  // checked.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid && valid_q[i] && (addr_q[i] == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_we;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_we     (st_we),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_we    = we;
    tick();
    st_valid = 1'b0;
  endtask

  logic [31:0] drain_addr [4];

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_we = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ld_valid = 1'b1;
    #1;
    // Reset state
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_addr",  mem_addr,       32'h0);
    check("rst_mem_wdata", mem_wdata,      32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_count",     32'(count),     32'd0);
    check("rst_st_ready",  32'(st_ready),  32'd1);
    check("rst_ld_hit",    32'(ld_hit),    32'd0);
    ld_valid = 1'b0;

    // sb at 0x1003 -> lane 3 strobe, request next cycle, stable while unacked
    put(32'h0000_1003, 32'hABAB_ABAB, 4'b0001);
    check("sb_mem_req",   32'(mem_req),   32'd1);
    check("sb_mem_addr",  mem_addr,       32'h0000_1000);
    check("sb_mem_wstrb", 32'(mem_wstrb), 32'h8);
    check("sb_mem_wdata", mem_wdata,      32'hABAB_ABAB);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_mem_req",   32'(mem_req),   32'd1);
      check("hold_mem_addr",  mem_addr,       32'h0000_1000);
      check("hold_mem_wstrb", 32'(mem_wstrb), 32'h8);
      check("hold_mem_wdata", mem_wdata,      32'hABAB_ABAB);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_ack_empty",   32'(empty),   32'd1);
    check("sb_ack_mem_req", 32'(mem_req), 32'd0);

    // Fill to full. The pointers start at 1, so the fill wraps.
    for (int i = 0; i < 4; i++) put(32'h100 + 32'(4*i), 32'(i), 4'b1111);
    check("full_count",    32'(count),    32'd4);
    check("full_st_ready", 32'(st_ready), 32'd0);
    check("full_mem_addr", mem_addr,      32'h100);
    // The 5th store is refused while the buffer is full.
    st_valid = 1'b1; st_addr = 32'h110; st_data = 32'd5; st_we = 4'b1111;
    tick();
    check("full_refuse_count", 32'(count), 32'd4);
    // st_valid and mem_ack together when full: only the dequeue happens.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("full_ack_count",    32'(count),    32'd3);
    check("full_ack_st_ready", 32'(st_ready), 32'd1);
    check("full_ack_mem_addr", mem_addr,      32'h104);
    // The 5th store now enters.
    tick();
    st_valid = 1'b0;
    check("fifth_count", 32'(count), 32'd4);
    // Continuous ack drains one entry per cycle, in FIFO order.
    drain_addr[0] = 32'h104; drain_addr[1] = 32'h108;
    drain_addr[2] = 32'h10C; drain_addr[3] = 32'h110;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_mem_req",  32'(mem_req), 32'd1);
      check("drain_mem_addr", mem_addr,     drain_addr[i]);
      tick();
    end
    check("drain_empty", 32'(empty), 32'd1);
    // An ack with no request is ignored.
    tick();
    mem_ack = 1'b0;
    check("stray_ack_count", 32'(count), 32'd0);
    check("stray_ack_empty", 32'(empty), 32'd1);

    // Load hit detection
    put(32'h2000, 32'hDEAD_BEEF, 4'b1111);
    ld_valid = 1'b1; ld_addr = 32'h2002; #1;
    check("ld_same_word", 32'(ld_hit), 32'd1);
    ld_addr = 32'h2004; #1;
    check("ld_next_word", 32'(ld_hit), 32'd0);
    ld_valid = 1'b0; ld_addr = 32'h2000; #1;
    check("ld_not_valid", 32'(ld_hit), 32'd0);
    ld_valid = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ld_after_ack", 32'(ld_hit), 32'd0);
    ld_valid = 1'b0;

    // A zero enable is accepted and dropped.
    put(32'h50, 32'h1, 4'b0000);
    check("drop_count", 32'(count), 32'd0);
    check("drop_empty", 32'(empty), 32'd1);

    // Reset mid-drain
    put(32'h40, 32'h1, 4'b1111);
    put(32'h44, 32'h2, 4'b1111);
    put(32'h48, 32'h3, 4'b1111);
    check("pre_rst_count",   32'(count),   32'd3);
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_mem_req",  32'(mem_req),  32'd0);
    check("mid_rst_count",    32'(count),    32'd0);
    check("mid_rst_empty",    32'(empty),    32'd1);
    check("mid_rst_st_ready", 32'(st_ready), 32'd1);
    check("mid_rst_mem_addr", mem_addr,      32'h0);

    // Same-word sb following an sh: merged or allocated, depending on build.
    put(32'h3000, 32'h1111_1111, 4'b1111);
    put(32'h3010, 32'h1234_1234, 4'b0011);
    put(32'h3011, 32'h5656_5656, 4'b0001);
`ifdef STORE_MERGE_EN
    check("merge_count", 32'(count), 32'd2);
`else
    check("merge_count", 32'(count), 32'd3);
`endif
    check("merge_head_addr", mem_addr, 32'h3000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("second_addr",  mem_addr,       32'h3010);
    check("second_wstrb", 32'(mem_wstrb), 32'h3);
`ifdef STORE_MERGE_EN
    check("second_wdata", mem_wdata, 32'h1234_5634);
`else
    check("second_wdata", mem_wdata, 32'h1234_1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("third_addr",  mem_addr,       32'h3010);
    check("third_wstrb", 32'(mem_wstrb), 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
